// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory for the MEM stage of the pipelined MIPS datapath.
// A load/store is accepted in IDLE, waits LATENCY cycles in BUSY, performs
// the array access on the last BUSY edge and pulses o_resp_valid for one
// cycle in RESP. o_stall holds the upstream pipeline while the access is in
// flight.
//
// Optional feature (compile-time macro MEM_ALIGN_CHECK_EN):
//   defined   - misaligned requests (address[1:0] != 0) take full latency,
//               do not write the array, return 0 and raise o_err in RESP.
//   undefined - address[1:0] is ignored and o_err is tied to 0.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous reset, active-low
//   i_req_valid   in   MEM stage presents a load or store
//   i_req_write   in   1 = store, 0 = load
//   i_address     in   byte address (ADDR_WIDTH)
//   i_wdata       in   store data (DATA_WIDTH)
//   o_req_ready   out  responder idle, a request can be accepted
//   o_resp_valid  out  one-cycle completion pulse
//   o_rdata       out  last load data, valid with o_resp_valid
//   o_stall       out  freezes PC and pipeline buffers
//   o_err         out  misaligned-access flag (RESP cycle only)
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_req_ready,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_stall,
  output logic                  o_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mis_q, mis_d;
  logic                  do_access;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Upper address bits are dropped on purpose (accesses wrap modulo DEPTH);
  // the low byte-offset bits are only consulted by the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[ADDR_WIDTH-1:IDX_W+2], i_address[1:0]};

  // Misalignment is captured at accept like the rest of the request.
  logic req_mis;
`ifdef MEM_ALIGN_CHECK_EN
  assign req_mis = |i_address[1:0];
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    rdata_d   = rdata_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          wr_d    = i_req_write;
          idx_d   = i_address[IDX_W+1:2];
          wdata_d = i_wdata;
          mis_d   = req_mis;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A misaligned access returns 0 for both loads and stores; an aligned
    // store leaves the last load value in place.
    if (do_access) begin
      if (mis_q) begin
        rdata_d = '0;
      end else if (!wr_q) begin
        rdata_d = mem_q[idx_q];
      end
    end
  end

  assign mem_we = do_access && wr_q && !mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is cleared by reset, so an aborted store leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_resp_valid = (state_q == RESP);
  assign o_rdata      = rdata_q;
  // Low in RESP so the pipeline advances on the edge that ends RESP.
  assign o_stall      = ((state_q == IDLE) && i_req_valid) || (state_q == BUSY);

`ifdef MEM_ALIGN_CHECK_EN
  assign o_err = (state_q == RESP) && mis_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
